int_adder_seq: RTL and testbench
================================

# int_adder_seq

Parametrised, multi-cycle integer adder/subtractor for the integer ALU. It processes a DATA_WIDTH-bit operation in CHUNK_WIDTH-bit slices, one slice per clock, and chains the carry between slices through a register. This trades latency for a short critical path. Operands enter and results leave through valid/ready handshakes, so the block plugs into the ALU datapath alongside the combinational ripple adder. It adds subtract mode, a live carry/borrow input, and signed-overflow and zero flags.

## Interface
- DATA_WIDTH, 32: operand and result width.
- CHUNK_WIDTH, 8: bits processed per cycle.
  - Must divide DATA_WIDTH exactly.
  - NUM_CHUNKS = DATA_WIDTH/CHUNK_WIDTH, and NUM_CHUNKS ≥ 1.
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block can accept operands.
- data_a  input  DATA_WIDTH  operand A.
- data_b  input  DATA_WIDTH  operand B.
- carry_in  input  1  carry in (add) or borrow in (sub).
- op_sub  input  1  0 = A+B+carry_in; 1 = A−B−carry_in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  DATA_WIDTH  result.
- carry_out  output  1  raw adder carry out of the MSB; in sub mode 1 means no borrow.
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready:
    - Capture a_reg = data_a.
    - Capture b_reg = op_sub ? ~data_b : data_b.
    - Set carry_reg = op_sub ? ~carry_in : carry_in.
    - Clear chunk index k=0 and enter BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle, compute slice k: {c, s} = a_reg[k] + b_reg[k] + carry_reg, at CHUNK_WIDTH+1 bits.
  - Write s into sum_reg slice k and c into carry_reg.
  - On the last slice (k = NUM_CHUNKS−1):
    - Record the carry into the MSB, i.e. the carry out of bit DATA_WIDTH−2, as msb_cin.
    - Go to DONE.
  - Otherwise k increments.
- DONE:
  - out_valid=1.
  - Outputs are held stable until out_ready=1, then the FSM returns to IDLE.
  - in_ready=0 in DONE; operations never overlap.
- Output values:
  - sum = sum_reg.
  - carry_out = final carry_reg.
  - overflow = msb_cin XOR carry_out.
  - zero = (sum_reg == 0).
- All arithmetic is modulo 2^DATA_WIDTH; there is no saturation.
- Inputs are sampled only at the accept edge. Changes to data_a, data_b, carry_in or op_sub during BUSY/DONE have no effect.
- in_valid while in BUSY/DONE is ignored; no operand is captured.
- Reset, including mid-operation:
  - The FSM goes to IDLE immediately and any in-flight operation is dropped.
  - Resulting values: in_ready=1, out_valid=0, sum=0, carry_out=0, overflow=0, zero=1.

## Timing
- Accept at edge T (in_valid && in_ready high in the cycle before T).
  - BUSY occupies cycles T..T+NUM_CHUNKS−1.
  - out_valid is high from the cycle after edge T+NUM_CHUNKS.
- Latency from accept to out_valid: NUM_CHUNKS+1 edges.
- With out_ready held high, in_ready returns one cycle after the result handshake.
- Throughput: one operation per NUM_CHUNKS+2 cycles.
- NUM_CHUNKS=1 (CHUNK_WIDTH=DATA_WIDTH) is legal: BUSY lasts exactly one cycle.
- All outputs are registered; there is no combinational path from any input to any output. The only exception is that in_ready depends on state only.

## Test plan
- Add with carry wrap: DATA_WIDTH=32, CHUNK_WIDTH=8, A=0xFFFFFFFF, B=0x00000001, carry_in=0, op_sub=0.
  - sum=0x00000000, carry_out=1, zero=1, overflow=0.
  - out_valid asserts 5 edges after accept.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, add.
  - sum=0x80000000, carry_out=0, overflow=1, zero=0.
  - Also: A=0x12345678, B=0x0000FFFF, carry_in=1 gives sum=0x12355678.
- Subtract: A=5, B=7, op_sub=1, carry_in=0.
  - sum=0xFFFFFFFE, carry_out=0 (borrow), overflow=0.
  - Also: A=0x80000000, B=1, sub gives sum=0x7FFFFFFF, overflow=1, carry_out=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid, while toggling data_a and driving in_valid=1.
  - sum and flags stay constant; in_ready stays 0; no second accept.
  - Raise out_ready: exactly one handshake, then in_ready=1 on the next cycle.
- Reset mid-operation: assert rst 2 cycles into BUSY.
  - Immediately out_valid=0, in_ready=1, sum=0, zero=1.
  - Next op after release (3+4) yields 7 with normal latency.
- Degenerate width: DATA_WIDTH=16, CHUNK_WIDTH=16, A=0xFFFF, B=0x0001.
  - sum=0x0000, carry_out=1.
  - out_valid 2 edges after accept.

Source files
------------

// File: rtl/int_adder_seq.sv
// int_adder_seq
// -------------
// Multi-cycle integer adder/subtractor. A DATA_WIDTH-bit operation is processed
// CHUNK_WIDTH bits per clock, least-significant slice first, with the carry
// between slices held in a register. This keeps the critical path to one
// CHUNK_WIDTH-bit add at the cost of NUM_CHUNKS cycles of latency.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds valid and its payload
// steady until that edge. Here in_ready depends only on FSM state. out_valid and
// the result stay constant until the consumer raises out_ready.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : operand set offered
//   in_ready   : block is IDLE and can accept operands
//   data_a     : operand A
//   data_b     : operand B
//   carry_in   : carry in (add) or borrow in (sub)
//   op_sub     : 0 = A+B+carry_in, 1 = A-B-carry_in
//   out_valid  : result valid (DONE state)
//   out_ready  : consumer accepts result
//   sum        : result, modulo 2^DATA_WIDTH
//   carry_out  : raw carry out of the MSB (sub: 1 = no borrow)
//   overflow   : two's-complement signed overflow
//   zero       : sum == 0
//   state_o    : current FSM state, for debug and observation
//
// CHUNK_WIDTH must divide DATA_WIDTH exactly. CHUNK_WIDTH == DATA_WIDTH is legal.
module int_adder_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  carry_in,
  input  logic                  op_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  zero,
  output logic [1:0]            state_o
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  // Slice-index width; kept at least 1 bit so the single-chunk case still
  // has a legal register.
  localparam int KW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [DATA_WIDTH-1:0]   sum_q, sum_d;
  logic                    carry_q, carry_d;
  logic                    msb_cin_q, msb_cin_d;
  logic [KW-1:0]           k_q, k_d;

  logic [CHUNK_WIDTH-1:0]  a_sl;
  logic [CHUNK_WIDTH-1:0]  b_sl;
  logic [CHUNK_WIDTH:0]    slice_res;
  logic                    last_slice;

  // Current slice operands, selected by k_q.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (k_q == KW'(i)) begin
        a_sl = a_q[i*CHUNK_WIDTH +: CHUNK_WIDTH];
        b_sl = b_q[i*CHUNK_WIDTH +: CHUNK_WIDTH];
      end
    end
  end

  assign slice_res  = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK_WIDTH{1'b0}}, carry_q};
  assign last_slice = (k_q == KW'(NUM_CHUNKS - 1));

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    msb_cin_d = msb_cin_q;
    k_d       = k_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + ~borrow_in, so the carry register
          // starts at 1 when there is no borrow.
          a_d     = data_a;
          b_d     = op_sub ? ~data_b : data_b;
          carry_d = carry_in ^ op_sub;
          k_d     = '0;
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        for (int i = 0; i < NUM_CHUNKS; i++) begin
          if (k_q == KW'(i)) begin
            sum_d[i*CHUNK_WIDTH +: CHUNK_WIDTH] = slice_res[CHUNK_WIDTH-1:0];
          end
        end
        carry_d = slice_res[CHUNK_WIDTH];
        if (last_slice) begin
          // The carry into the MSB is recovered from that bit's sum:
          // s = a ^ b ^ cin, so cin = a ^ b ^ s.
          msb_cin_d = a_sl[CHUNK_WIDTH-1] ^ b_sl[CHUNK_WIDTH-1] ^
                      slice_res[CHUNK_WIDTH-1];
          state_d   = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      k_q       <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      msb_cin_q <= msb_cin_d;
      k_q       <= k_d;
    end
  end

  // All outputs come straight from registers (zero and overflow are
  // derived from registered values only).
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign carry_out = carry_q;
  assign overflow  = msb_cin_q ^ carry_q;
  assign zero      = (sum_q == '0);
  assign state_o   = state_q;

endmodule

// File: tb/tb_int_adder_seq.sv
module tb_int_adder_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32/8 instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_a = '0;
  logic [31:0] data_b = '0;
  logic        carry_in = 1'b0;
  logic        op_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        carry_out, overflow, zero;
  logic [1:0]  dbg_state;

  int_adder_seq #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_a(data_a), .data_b(data_b),
    .carry_in(carry_in), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow), .zero(zero),
    .state_o(dbg_state)
  );

  // 16/16 instance (single chunk)
  logic        v16 = 1'b0;
  logic        r16;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        cin16 = 1'b0;
  logic        sub16 = 1'b0;
  logic        ov16;
  logic        ordy16 = 1'b1;
  logic [15:0] sum16;
  logic        cout16, ovf16, zero16;
  logic [1:0]  dbg_state16;

  int_adder_seq #(.DATA_WIDTH(16), .CHUNK_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(v16), .in_ready(r16),
    .data_a(a16), .data_b(b16),
    .carry_in(cin16), .op_sub(sub16),
    .out_valid(ov16), .out_ready(ordy16),
    .sum(sum16), .carry_out(cout16), .overflow(ovf16), .zero(zero16),
    .state_o(dbg_state16)
  );

  // ---------------- scoreboard ----------------
  // Expected record: {sum[31:0], carry_out, overflow, zero}
  localparam int W = 35;
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: exact arithmetic, independent of slicing.
  function automatic logic [W-1:0] model32(input logic [31:0] a, input logic [31:0] b,
                                           input logic cin, input logic sub);
    logic [32:0] full;
    logic [31:0] s;
    logic        c;
    longint      t;
    if (!sub) begin
      full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      s    = full[31:0];
      c    = full[32];
      t    = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end else begin
      s = a - b - {31'd0, cin};
      c = ({1'b0, a} >= ({1'b0, b} + {32'd0, cin}));
      t = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
    end
    return {s, c, (t > 64'sd2147483647) || (t < -64'sd2147483648), (s == 32'd0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                      input logic sub, input logic [W-1:0] exp);
    @(negedge clk);
    chk("ready_before_accept", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    data_a   = a;
    data_b   = b;
    carry_in = cin;
    op_sub   = sub;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    // Scramble inputs after accept; they must be ignored.
    in_valid = 1'b0;
    data_a   = $urandom;
    data_b   = $urandom;
    carry_in = 1'($urandom_range(0, 1));
    op_sub   = 1'($urandom_range(0, 1));
  endtask

  // Waits for out_valid (the accept edge counts as edge 1) and compares.
  task automatic collect(input string tag, input int exp_lat, output logic [W-1:0] got_exp);
    int edges;
    logic [W-1:0] e;
    edges   = 1;
    got_exp = '0;
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: out_valid low after %0d edges, expected high", tag, edges);
    end else begin
      chk({tag, "_latency"}, 64'(edges), 64'(exp_lat));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_sb_empty: result with no expected entry", tag);
      end else begin
        e = exp_q.pop_front();
        got_exp = e;
        chk({tag, "_sum"},  {32'd0, sum},       {32'd0, e[34:3]});
        chk({tag, "_cout"}, {63'd0, carry_out}, {63'd0, e[2]});
        chk({tag, "_ovf"},  {63'd0, overflow},  {63'd0, e[1]});
        chk({tag, "_zero"}, {63'd0, zero},      {63'd0, e[0]});
      end
    end
  endtask

  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub,
                      input logic [15:0] es, input logic ec, input logic eo);
    int edges;
    @(negedge clk);
    v16 = 1'b1; a16 = a; b16 = b; cin16 = cin; sub16 = sub;
    @(posedge clk);
    #1;
    v16 = 1'b0; a16 = 16'($urandom);
    edges = 1;
    while (!ov16 && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, "_latency"}, 64'(edges), 64'd2);
    chk({tag, "_sum"},  {48'd0, sum16},  {48'd0, es});
    chk({tag, "_cout"}, {63'd0, cout16}, {63'd0, ec});
    chk({tag, "_ovf"},  {63'd0, ovf16},  {63'd0, eo});
    @(posedge clk);
    #1;
    chk({tag, "_ready_after"}, {63'd0, r16}, 64'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] e;
    logic [31:0]  ra, rb;
    logic         rc, rs;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum",       {32'd0, sum},       64'd0);
    chk("rst_cout",      {63'd0, carry_out}, 64'd0);
    chk("rst_ovf",       {63'd0, overflow},  64'd0);
    chk("rst_zero",      {63'd0, zero},      64'd1);
    chk("rst16_ready",   {63'd0, r16},       64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Hand-derived table
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, {32'h00000000, 1'b1, 1'b0, 1'b1}});
    vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {32'h80000000, 1'b0, 1'b1, 1'b0}});
    vecs.push_back('{32'h12345678, 32'h0000FFFF, 1'b1, 1'b0, {32'h12355678, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b1, {32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{32'h80000000, 32'h00000001, 1'b0, 1'b1, {32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}});
    vecs.push_back('{32'h00000000, 32'h00000000, 1'b1, 1'b1, {32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{32'h00000005, 32'h00000005, 1'b0, 1'b1, {32'h00000000, 1'b1, 1'b0, 1'b1}});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, {32'hFFFFFFFF, 1'b1, 1'b0, 1'b0}});
    vecs.push_back('{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, {32'h01000100, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{32'h80000000, 32'h00000000, 1'b1, 1'b1, {32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}});
    // Random vectors, expected values from the model
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = (i % 5 == 0) ? ra : $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      vecs.push_back('{ra, rb, rc, rs, model32(ra, rb, rc, rs)});
    end

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp);
      collect($sformatf("vec%0d", i), 5, e);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ready_after", i), {63'd0, in_ready}, 64'd1);
      chk($sformatf("vec%0d_valid_after", i), {63'd0, out_valid}, 64'd0);
    end

    // Backpressure: result held, no second accept
    out_ready = 1'b0;
    send(32'h00000003, 32'h00000004, 1'b0, 1'b0, {32'h00000007, 1'b0, 1'b0, 1'b0});
    collect("bp", 5, e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_a   = $urandom;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_hold_sum",   {32'd0, sum},       {32'd0, e[34:3]});
      chk("bp_hold_cout",  {63'd0, carry_out}, {63'd0, e[2]});
      chk("bp_hold_zero",  {63'd0, zero},      {63'd0, e[0]});
      chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_hold_ready", {63'd0, in_ready},  64'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_release_ready", {63'd0, in_ready},  64'd1);
    @(posedge clk);
    #1;
    chk("bp_no_second_accept", {63'd0, in_ready}, 64'd1);

    // Reset two cycles into BUSY
    send(32'h11111111, 32'h22222222, 1'b0, 1'b0, model32(32'h11111111, 32'h22222222, 1'b0, 1'b0));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_ready", {63'd0, in_ready},  64'd1);
    chk("midrst_sum",   {32'd0, sum},       64'd0);
    chk("midrst_zero",  {63'd0, zero},      64'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    send(32'd3, 32'd4, 1'b0, 1'b0, {32'd7, 1'b0, 1'b0, 1'b0});
    collect("post_rst", 5, e);
    @(posedge clk);
    #1;

    // Single-chunk instance
    op16("deg_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16("deg_sub",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    op16("deg_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
